// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC router constants, port indices and port FSM encoding
package noc_pkg;
  localparam int DATA_WIDTH = 37;
  localparam int NUM_PORTS  = 5;

  localparam logic [2:0] PORT_W = 3'd0;
  localparam logic [2:0] PORT_S = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_N = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } port_state_t;

  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p >= PORT_L) ? PORT_W : p + 3'd1;
  endfunction
endpackage

// File: rtl/rr_arbiter5.sv
// rtl/rr_arbiter5.sv - five-way round-robin arbiter, scan starts at ptr and ascends mod 5
module rr_arbiter5
  import noc_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] grant,
  output logic [2:0] grant_idx,
  output logic       valid
);

  logic [2:0] scan;

  always_comb begin
    grant     = '0;
    grant_idx = PORT_W;
    valid     = 1'b0;
    // an out-of-range pointer restarts the scan at W
    scan      = (ptr > PORT_L) ? PORT_W : ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!valid && req[scan]) begin
        valid     = 1'b1;
        grant_idx = scan;
      end
      scan = next_port(scan);
    end
    if (valid) grant = 5'b00001 << grant_idx;
  end

endmodule

// File: rtl/in_port.sv
// rtl/in_port.sv - router input port: arbitrates five four-phase senders into one FIFO write stream
module in_port
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataInL,
  input  logic [DATA_WIDTH-1:0] dataInN,
  input  logic [DATA_WIDTH-1:0] dataInE,
  input  logic [DATA_WIDTH-1:0] dataInS,
  input  logic [DATA_WIDTH-1:0] dataInW,
  input  logic                  Inr_L,
  input  logic                  Inr_N,
  input  logic                  Inr_E,
  input  logic                  Inr_S,
  input  logic                  Inr_W,
  output logic                  Inw_L,
  output logic                  Inw_N,
  output logic                  Inw_E,
  output logic                  Inw_S,
  output logic                  Inw_W,
  output logic [DATA_WIDTH-1:0] DataFiFo,
  output logic                  wrreq,
  input  logic                  full
);

  logic [4:0]            req;
  logic [DATA_WIDTH-1:0] data_in [NUM_PORTS];

  port_state_t           state, state_d;
  logic [2:0]            rr_ptr, rr_ptr_d;
  logic [2:0]            gnt_idx, gnt_idx_d;
  logic [4:0]            inw, inw_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wrreq_q, wrreq_d;

  logic [4:0]            arb_grant;
  logic [2:0]            arb_idx;
  logic                  arb_valid;

  assign req = {Inr_L, Inr_N, Inr_E, Inr_S, Inr_W};

  assign data_in[PORT_W] = dataInW;
  assign data_in[PORT_S] = dataInS;
  assign data_in[PORT_E] = dataInE;
  assign data_in[PORT_N] = dataInN;
  assign data_in[PORT_L] = dataInL;

  rr_arbiter5 u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rr_ptr  <= PORT_W;
      gnt_idx <= PORT_W;
      inw     <= '0;
      data_q  <= '0;
      wrreq_q <= 1'b0;
    end else begin
      state   <= state_d;
      rr_ptr  <= rr_ptr_d;
      gnt_idx <= gnt_idx_d;
      inw     <= inw_d;
      data_q  <= data_d;
      wrreq_q <= wrreq_d;
    end
  end

  always_comb begin
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    gnt_idx_d = gnt_idx;
    inw_d     = inw;
    data_d    = data_q;
    wrreq_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        inw_d = '0;
        if (!full && arb_valid) begin
          data_d    = data_in[arb_idx];
          wrreq_d   = 1'b1;
          inw_d     = arb_grant;
          gnt_idx_d = arb_idx;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        // acknowledge tracks the granted request; its fall closes the handshake
        if (!req[gnt_idx]) begin
          inw_d    = '0;
          rr_ptr_d = next_port(gnt_idx);
          state_d  = ST_IDLE;
        end
      end
      default: begin
        inw_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign DataFiFo = data_q;
  assign wrreq    = wrreq_q;
  assign Inw_W    = inw[0];
  assign Inw_S    = inw[1];
  assign Inw_E    = inw[2];
  assign Inw_N    = inw[3];
  assign Inw_L    = inw[4];

endmodule

// File: tb/tb_in_port.sv
// tb/tb_in_port.sv - directed self-checking bench for in_port
module tb_in_port;

  localparam int DW = 37;

  logic          clk;
  logic          reset;
  logic [DW-1:0] din [5];
  logic [4:0]    req;
  logic          full;
  logic          Inw_L, Inw_N, Inw_E, Inw_S, Inw_W;
  logic [DW-1:0] DataFiFo;
  logic          wrreq;
  logic [4:0]    ack_v;

  int n_vec = 0;
  int n_bad = 0;

  int wr_cnt = 0;
  int ack_rise = 0;
  int onehot_viol = 0;
  int full_viol = 0;
  logic [4:0] prev_ack = '0;
  logic full_q = 1'b0;

  logic [DW-1:0] pat [5];

  in_port dut (
    .clk      (clk),
    .reset    (reset),
    .dataInL  (din[4]),
    .dataInN  (din[3]),
    .dataInE  (din[2]),
    .dataInS  (din[1]),
    .dataInW  (din[0]),
    .Inr_L    (req[4]),
    .Inr_N    (req[3]),
    .Inr_E    (req[2]),
    .Inr_S    (req[1]),
    .Inr_W    (req[0]),
    .Inw_L    (Inw_L),
    .Inw_N    (Inw_N),
    .Inw_E    (Inw_E),
    .Inw_S    (Inw_S),
    .Inw_W    (Inw_W),
    .DataFiFo (DataFiFo),
    .wrreq    (wrreq),
    .full     (full)
  );

  assign ack_v = {Inw_L, Inw_N, Inw_E, Inw_S, Inw_W};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) full_q <= full;

  always @(negedge clk) begin
    if ((ack_v & (ack_v - 5'd1)) != 5'd0) onehot_viol++;
    if (wrreq) begin
      wr_cnt++;
      if (full_q) full_viol++;
    end
    if (ack_v != 5'd0 && prev_ack == 5'd0) ack_rise++;
    prev_ack = ack_v;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic wait_wr(input string tag);
    int k;
    k = 0;
    step(1);
    while (!wrreq && k < 10) begin
      step(1);
      k++;
    end
    chk(tag, wrreq, 1);
  endtask

  initial begin
    int wr_n;
    int ack_n;
    pat[0] = 37'h0_1111_0000;
    pat[1] = 37'h0_2222_0001;
    pat[2] = 37'h0_3333_0002;
    pat[3] = 37'h0_4444_0003;
    pat[4] = 37'h1_5555_0004;
    for (int i = 0; i < 5; i++) din[i] = '0;
    req   = '0;
    full  = 1'b0;
    reset = 1'b0;
    step(2);
    chk("rst_wrreq", wrreq, 0);
    chk("rst_inw", ack_v, 0);
    chk("rst_data", DataFiFo, 0);
    reset = 1'b1;
    step(1);

    // single E request
    din[2] = 37'h1_0000_0005;
    req[2] = 1'b1;
    step(1);
    chk("e_wrreq", wrreq, 1);
    chk("e_data", DataFiFo, 37'h1_0000_0005);
    chk("e_inw", ack_v, 5'b00100);
    req[2] = 1'b0;
    step(1);
    chk("e_inw_drop", ack_v, 0);
    chk("e_wrreq_drop", wrreq, 0);
    chk("e_data_hold", DataFiFo, 37'h1_0000_0005);

    // all five requesting: W,S,E,N,L then W before L
    do_reset();
    for (int i = 0; i < 5; i++) din[i] = pat[i];
    req = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      wait_wr($sformatf("rr_wr%0d", i));
      chk($sformatf("rr_inw%0d", i), ack_v, 5'b00001 << i);
      chk($sformatf("rr_data%0d", i), DataFiFo, pat[i]);
      req[i] = 1'b0;
    end
    step(1);
    req[0] = 1'b1;
    req[4] = 1'b1;
    wait_wr("wrap_wr_w");
    chk("wrap_inw_w", ack_v, 5'b00001);
    req[0] = 1'b0;
    wait_wr("wrap_wr_l");
    chk("wrap_inw_l", ack_v, 5'b10000);
    chk("wrap_data_l", DataFiFo, pat[4]);
    req[4] = 1'b0;
    step(1);

    // FIFO full blocks the grant
    full   = 1'b1;
    din[3] = 37'h0_0ABC_DEF3;
    req[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("full_blk%0d", i), {wrreq, ack_v}, 6'd0);
    end
    full = 1'b0;
    step(1);
    chk("full_rel_wr", wrreq, 1);
    chk("full_rel_inw", ack_v, 5'b01000);
    chk("full_rel_data", DataFiFo, 37'h0_0ABC_DEF3);
    req[3] = 1'b0;
    step(1);

    // S held high: one write, six acknowledged cycles
    din[1] = 37'h0_5A5A_0001;
    req[1] = 1'b1;
    step(1);
    chk("hold_inw_first", ack_v, 5'b00010);
    wr_n  = 0;
    ack_n = 0;
    for (int i = 0; i < 7; i++) begin
      wr_n  += int'(wrreq);
      ack_n += int'(ack_v[1]);
      if (i == 5) req[1] = 1'b0;
      step(1);
    end
    chk("hold_wr_count", wr_n, 1);
    chk("hold_ack_cycles", ack_n, 6);
    chk("hold_idle_inw", ack_v, 0);

    // asynchronous reset in the middle of an L handshake
    din[4] = 37'h1_CAFE_0004;
    req[4] = 1'b1;
    step(1);
    chk("ar_pre_inw", ack_v, 5'b10000);
    chk("ar_pre_wr", wrreq, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_inw", ack_v, 0);
    chk("ar_wrreq", wrreq, 0);
    chk("ar_data", DataFiFo, 0);
    step(1);
    reset = 1'b1;
    step(1);
    chk("ar_regrant_wr", wrreq, 1);
    chk("ar_regrant_inw", ack_v, 5'b10000);
    chk("ar_regrant_data", DataFiFo, 37'h1_CAFE_0004);
    req[4] = 1'b0;
    step(2);
    chk("ar_end_inw", ack_v, 0);

    chk("onehot_viol", onehot_viol, 0);
    chk("wr_while_full", full_viol, 0);
    chk("wr_vs_ack_rise", wr_cnt, ack_rise);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
